// File: rtl/db_mode_ctrl.sv
// db_mode_ctrl: turns debounced button levels into persistent position and
// data-format settings. HS/VS step positions with hold-to-auto-repeat;
// DF_UART/DF_VGA cycle 2-bit format codes on each press.

// Per-button press/hold/repeat sequencer; emits a one-cycle step strobe.
module db_rep_fsm #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,    // current debounced level
  input  logic press_i,  // rising edge of lvl_i
  output logic step_o
);
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} st_t;

  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter register; reset aborts any hold/repeat in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state: release is checked before terminal count so release wins.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    step_o = 1'b0;
    case (st_q)
      IDLE: begin
        if (press_i) begin
          step_o = 1'b1;
          cnt_d  = '0;
          st_d   = HOLD;
        end
      end
      HOLD: begin
        if (!lvl_i) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == HOLD_TC) begin
          step_o = 1'b1;
          cnt_d  = '0;
          st_d   = RPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RPT: begin
        if (!lvl_i) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == RPT_TC) begin
          step_o = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end
endmodule

module db_mode_ctrl #(
  parameter int POS_W         = 10,
  parameter int H_MAX         = 639,
  parameter int V_MAX         = 479,
  parameter int FMT_MAX       = 3,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HS,
  input  logic             VS,
  input  logic             DF_UART,
  input  logic             DF_VGA,
  output logic [POS_W-1:0] h_pos,
  output logic [POS_W-1:0] v_pos,
  output logic [1:0]       uart_fmt,
  output logic [1:0]       vga_fmt,
  output logic             changed
);
  localparam logic [POS_W-1:0] H_TOP = POS_W'(H_MAX);
  localparam logic [POS_W-1:0] V_TOP = POS_W'(V_MAX);
  localparam logic [1:0]       F_TOP = 2'(FMT_MAX);

  // bit order: {DF_VGA, DF_UART, VS, HS}
  logic [3:0] btn, in_q, press;
  logic [1:0] step;   // {v, h}

  logic [POS_W-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]       uf_q, uf_d, vf_q, vf_d;
  logic             chg_q, chg_d;

  assign btn   = {DF_VGA, DF_UART, VS, HS};
  assign press = btn & ~in_q;

  // One sequencer per position button.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    db_rep_fsm #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .lvl_i  (btn[g]),
      .press_i(press[g]),
      .step_o (step[g])
    );
  end

  // Setting updates with wrap; changed flags any edge that altered a setting.
  always_comb begin
    h_d   = step[0]  ? ((h_q  == H_TOP) ? '0 : h_q + POS_W'(1)) : h_q;
    v_d   = step[1]  ? ((v_q  == V_TOP) ? '0 : v_q + POS_W'(1)) : v_q;
    uf_d  = press[2] ? ((uf_q == F_TOP) ? '0 : uf_q + 2'd1)     : uf_q;
    vf_d  = press[3] ? ((vf_q == F_TOP) ? '0 : vf_q + 2'd1)     : vf_q;
    chg_d = (h_d != h_q) | (v_d != v_q) | (uf_d != uf_q) | (vf_d != vf_q);
  end

  // Level history starts high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '1;
      h_q   <= '0;
      v_q   <= '0;
      uf_q  <= '0;
      vf_q  <= '0;
      chg_q <= 1'b0;
    end else begin
      in_q  <= btn;
      h_q   <= h_d;
      v_q   <= v_d;
      uf_q  <= uf_d;
      vf_q  <= vf_d;
      chg_q <= chg_d;
    end
  end

  assign h_pos    = h_q;
  assign v_pos    = v_q;
  assign uart_fmt = uf_q;
  assign vga_fmt  = vf_q;
  assign changed  = chg_q;
endmodule

// File: tb/tb_db_mode_ctrl.sv
// Directed bench for db_mode_ctrl with short hold/repeat counts.
module tb_db_mode_ctrl;
  localparam int POS_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             HS = 1'b0, VS = 1'b0, DF_UART = 1'b0, DF_VGA = 1'b0;
  logic [POS_W-1:0] h_pos, v_pos;
  logic [1:0]       uart_fmt, vga_fmt;
  logic             changed;

  int n_vec = 0;
  int n_err = 0;

  db_mode_ctrl #(
    .POS_W(POS_W), .H_MAX(5), .V_MAX(3), .FMT_MAX(3),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .HS(HS), .VS(VS), .DF_UART(DF_UART), .DF_VGA(DF_VGA),
    .h_pos(h_pos), .v_pos(v_pos), .uart_fmt(uart_fmt), .vga_fmt(vga_fmt),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // one edge; inputs change and outputs are read 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".h"}, int'(h_pos), 0);
    chk({tag, ".v"}, int'(v_pos), 0);
    chk({tag, ".uf"}, int'(uart_fmt), 0);
    chk({tag, ".vf"}, int'(vga_fmt), 0);
    chk({tag, ".chg"}, int'(changed), 0);
  endtask

  initial begin
    int pulses;
    int exp_h;
    int exp_c;

    // 1: DF_UART held through reset is not a press
    DF_UART = 1'b1;
    tick(); tick();
    chk_all0("rst");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(changed);
    end
    chk("held_uf", int'(uart_fmt), 0);
    chk("held_pulses", pulses, 0);
    DF_UART = 1'b0; tick();
    DF_UART = 1'b1; tick();
    chk("uf_press", int'(uart_fmt), 1);
    chk("uf_chg", int'(changed), 1);
    tick();
    chk("uf_chg_off", int'(changed), 0);
    DF_UART = 1'b0; tick();

    // 2: vga_fmt cycles 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      DF_VGA = 1'b1; tick();
      chk("vf_step", int'(vga_fmt), (i + 1) % 4);
      chk("vf_chg", int'(changed), 1);
      tick();
      chk("vf_chg_off", int'(changed), 0);
      DF_VGA = 1'b0; tick();
    end

    // 3: HS hold, steps at e0,e8,e12,e16,e20
    HS = 1'b1; tick();
    chk("h_e0", int'(h_pos), 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_h = (k < 8) ? 1 : 2 + (k - 8) / 4;
      exp_c = (k >= 8 && (k % 4) == 0) ? 1 : 0;
      chk($sformatf("h_e%0d", k), int'(h_pos), exp_h);
      chk($sformatf("hchg_e%0d", k), int'(changed), exp_c);
    end
    HS = 1'b0; tick();
    HS = 1'b1; tick();
    chk("h_wrap", int'(h_pos), 0);
    HS = 1'b0; tick();

    // 4: VS released exactly at terminal count -> no step
    VS = 1'b1; tick();
    chk("v_e0", int'(v_pos), 1);
    for (int k = 1; k < 8; k++) tick();
    VS = 1'b0; tick();
    chk("v_rel_tc", int'(v_pos), 1);
    chk("v_rel_chg", int'(changed), 0);
    VS = 1'b1; tick();
    chk("v_repress", int'(v_pos), 2);
    VS = 1'b0; tick();

    // 5: all four buttons on one edge from reset
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    {HS, VS, DF_UART, DF_VGA} = 4'b1111; tick();
    chk("all.h", int'(h_pos), 1);
    chk("all.v", int'(v_pos), 1);
    chk("all.uf", int'(uart_fmt), 1);
    chk("all.vf", int'(vga_fmt), 1);
    chk("all.chg", int'(changed), 1);
    tick();
    chk("all.chg_off", int'(changed), 0);
    {HS, VS, DF_UART, DF_VGA} = 4'b0000; tick();

    // 6: reset during REPEAT aborts; held HS must be re-pressed
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    HS = 1'b1; tick();
    for (int k = 1; k <= 12; k++) tick();
    chk("rpt_h", int'(h_pos), 3);
    rst = 1'b1; tick();
    chk_all0("midrst");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(changed);
    end
    chk("post_rst_h", int'(h_pos), 0);
    chk("post_rst_pulses", pulses, 0);
    HS = 1'b0; tick();
    HS = 1'b1; tick();
    chk("post_rst_press", int'(h_pos), 1);
    HS = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/db_mode_ctrl.md
# db_mode_ctrl

Consumes the four debounced button levels (HS, VS, DF_UART, DF_VGA) produced by the debouncer bank and turns them into persistent user settings. HS/VS presses step a horizontal/vertical position with hold-to-auto-repeat. DF_UART/DF_VGA presses cycle a 2-bit data-format selector for the UART and VGA paths. It sits directly downstream of the debouncer bank and feeds the UART and VGA blocks.

## Interface
Parameters:
- POS_W, 10: width of h_pos / v_pos.
- H_MAX, 639: largest h_pos value; wraps to 0 after it.
- V_MAX, 479: largest v_pos value; wraps to 0 after it.
- FMT_MAX, 3: largest format code; wraps to 0 after it (must be ≤ 3).
- HOLD_CYCLES, 50_000_000: cycles a button is held after the press update before the first auto-repeat step (≥ 2).
- REPEAT_CYCLES, 5_000_000: cycles between subsequent auto-repeat steps (≥ 2).

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- HS  in  1  debounced level, horizontal step button.
- VS  in  1  debounced level, vertical step button.
- DF_UART  in  1  debounced level, UART format button.
- DF_VGA  in  1  debounced level, VGA format button.
- h_pos  out  POS_W  horizontal position setting.
- v_pos  out  POS_W  vertical position setting.
- uart_fmt  out  2  UART data-format code.
- vga_fmt  out  2  VGA data-format code.
- changed  out  1  one-cycle pulse on any setting update.

## Operation
- Each input has a history register `in_q`. Press = `in & ~in_q`. `in_q` resets to 1, so a button held through reset does not count as a press. It must first be seen low.
- DF_UART press: uart_fmt ← (uart_fmt == FMT_MAX) ? 0 : uart_fmt+1. DF_VGA and vga_fmt behave the same way. Format buttons have no auto-repeat.
- HS and VS each run an independent FSM with counter `cnt`, width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)):
  - IDLE: on press → step position, cnt←0, go HOLD.
  - HOLD: input low → IDLE, cnt←0. Else if cnt == HOLD_CYCLES-1 → step, cnt←0, go REPEAT. Else cnt+1.
  - REPEAT: input low → IDLE, cnt←0. Else if cnt == REPEAT_CYCLES-1 → step, cnt←0. Else cnt+1.
- Step: h_pos ← (h_pos == H_MAX) ? 0 : h_pos+1. v_pos uses V_MAX the same way. Positions are unsigned. They never exceed H_MAX/V_MAX.
- Release wins: if the input is sampled low on the same edge the counter reaches terminal count, no step occurs.
- All four channels are independent. Simultaneous events on several channels all apply on the same edge.
- changed is registered. It is 1 after every edge on which at least one of the four settings changed, and 0 otherwise. One pulse is produced even when several settings change together.

## Timing
- Reset (synchronous, rst high at an edge): h_pos=0, v_pos=0, uart_fmt=0, vga_fmt=0, changed=0, both FSMs IDLE, cnt=0, all in_q=1.
- Reset mid-operation, including during HOLD/REPEAT, aborts immediately with no step. After reset, a held button must be released and pressed again.
- Press latency: the setting updates on the first rising edge at which the input is sampled high. changed is high for exactly that following cycle.
- Auto-repeat: first repeat step occurs HOLD_CYCLES edges after the press-update edge. Each further step occurs REPEAT_CYCLES edges after the previous one, for as long as the input stays high.
- A held level never produces a second press. A new press requires at least one cycle sampled low.
- Inputs are assumed already synchronous to clk; no synchronizer is added here.

## Test plan
Use bench parameters HOLD_CYCLES=8, REPEAT_CYCLES=4, H_MAX=5, V_MAX=3, POS_W=4.
- Reset with DF_UART held high, release rst, keep DF_UART high 20 cycles → uart_fmt stays 0, changed never pulses. Drop then raise DF_UART → uart_fmt=1 on that edge, one changed pulse.
- Four separate 2-cycle DF_VGA presses → vga_fmt goes 1,2,3,0. Four changed pulses.
- Hold HS high 20 cycles from press edge e0 → h_pos steps at e0, e8, e12, e16, e20, giving 1,2,3,4,5. Release, then one more press → h_pos wraps to 0.
- Hold VS so that it is sampled low exactly at edge e0+8 → v_pos stays 1 and the FSM returns to IDLE. Press again → v_pos=2.
- Press HS, VS, DF_UART, DF_VGA on the same edge from reset → h_pos=1, v_pos=1, uart_fmt=1, vga_fmt=1, and a single one-cycle changed pulse.
- Hold HS into REPEAT (h_pos=3), assert rst for 1 cycle with HS still high → all outputs 0, and no steps afterward until HS is released and pressed again.
